// File: rtl/ter_cyclic_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ter_pkg
// Brief    : Z3 trit encoding, mod-3 arithmetic helpers and FSM states.
// Revision : 1.0
// ============================================================================
package ter_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic trit_t ter_norm(input trit_t t);
        return (t == 2'b10) ? TRIT_ZERO : t;
    endfunction

    function automatic trit_t ter_add(input trit_t a, input trit_t b);
        trit_t na;
        trit_t nb;
        na = ter_norm(a);
        nb = ter_norm(b);
        if (!na[0])       return nb;
        else if (!nb[0]) return na;
        // Equal signs wrap: 1+1 = -1, -1+-1 = +1; opposite signs cancel.
        else if (na == nb) return {~na[1], 1'b1};
        else               return TRIT_ZERO;
    endfunction

    function automatic trit_t ter_mul(input trit_t a, input trit_t b);
        trit_t na;
        trit_t nb;
        na = ter_norm(a);
        nb = ter_norm(b);
        if (!na[0] || !nb[0]) return TRIT_ZERO;
        else                  return {na[1] ^ nb[1], 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ter_cyclic_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : ter_cyclic_mul_if
// Brief    : Operand load, a-stream and c-stream handshake bundle.
// Revision : 1.0
// ============================================================================
interface ter_cyclic_mul_if #(
    parameter int N     = 701,
    parameter int STEPS = 2
);
    logic               start;
    logic [2*N-1:0]     b_in;
    logic               a_valid;
    logic               a_ready;
    logic [2*STEPS-1:0] a_data;
    logic               c_valid;
    logic               c_ready;
    logic [2*STEPS-1:0] c_data;
    logic               c_last;
    logic               busy;

    modport master (
        output start, b_in, a_valid, a_data, c_ready,
        input  a_ready, c_valid, c_data, c_last, busy
    );

    modport slave (
        input  start, b_in, a_valid, a_data, c_ready,
        output a_ready, c_valid, c_data, c_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/ter_mac_step.sv
`default_nettype none
// ============================================================================
// Module   : ter_mac_step
// Brief    : One trit of a times the current b rotation, then rotate b by one.
// Revision : 1.0
// ============================================================================
module ter_mac_step
    import ter_pkg::*;
#(
    parameter int N = 701
) (
    input  wire logic [2*N-1:0] i_acc,
    input  wire logic [2*N-1:0] i_brot,
    input  wire logic [1:0]     i_a_trit,
    input  wire logic           i_en,
    output logic      [2*N-1:0] o_acc,
    output logic      [2*N-1:0] o_brot
);

    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            assign o_acc[2*j +: 2]  = ter_add(i_acc[2*j +: 2],
                                      i_en ? ter_mul(i_a_trit, i_brot[2*j +: 2]) : TRIT_ZERO);
            assign o_brot[2*j +: 2] = i_brot[2*((j + N - 1) % N) +: 2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ter_cyclic_mul.sv
`default_nettype none
// ============================================================================
// Module   : ter_cyclic_mul
// Brief    : Sequential c = a*b mod (x^N - 1) over Z3, STEPS a-trits per beat.
// Revision : 1.0
// ============================================================================
module ter_cyclic_mul #(
    parameter int N     = 701,
    parameter int STEPS = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ter_cyclic_mul_if.slave  bus
);
    import ter_pkg::*;

    localparam int BEATS = (N + STEPS - 1) / STEPS;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CW-1:0]               r_count;
    logic [2*N-1:0]              r_acc;
    logic [2*N-1:0]              r_brot;
    logic [2*STEPS-1:0]          r_c_data;
    logic                        r_c_last;
    logic [2*N-1:0]              w_b_norm;
    logic [STEPS:0][2*N-1:0]     w_acc;
    logic [STEPS:0][2*N-1:0]     w_brot;
    logic [STEPS-1:0]            w_en;
    logic [2*N-1:0]              w_src;
    logic [CW-1:0]               w_beat;
    logic [2*STEPS-1:0]          w_c_data;
    logic                        w_a_fire;
    logic                        w_c_fire;
    logic                        w_last_beat;

    assign bus.a_ready = (r_state == MAC);
    assign bus.c_valid = (r_state == DRAIN);
    assign bus.busy    = (r_state != IDLE);
    assign bus.c_data  = r_c_data;
    assign bus.c_last  = r_c_last;

    assign w_a_fire    = (r_state == MAC)   && bus.a_valid;
    assign w_c_fire    = (r_state == DRAIN) && bus.c_ready;
    assign w_last_beat = (r_count == LAST_BEAT);

    generate
        for (genvar j = 0; j < N; j++) begin : g_bnorm
            assign w_b_norm[2*j +: 2] = ter_norm(bus.b_in[2*j +: 2]);
        end
    endgenerate

    // Padding trits of the final beat must not touch the accumulator.
    always_comb begin
        w_en = '0;
        for (int s = 0; s < STEPS; s++) begin
            w_en[s] = ((int'(r_count) * STEPS + s) < N);
        end
    end

    assign w_acc[0]  = r_acc;
    assign w_brot[0] = r_brot;

    generate
        for (genvar s = 0; s < STEPS; s++) begin : g_step
            ter_mac_step #(.N(N)) u_step (
                .i_acc    (w_acc[s]),
                .i_brot   (w_brot[s]),
                .i_a_trit (bus.a_data[2*s +: 2]),
                .i_en     (w_en[s]),
                .o_acc    (w_acc[s+1]),
                .o_brot   (w_brot[s+1])
            );
        end
    endgenerate

    // Next result beat: beat 0 comes straight from the final MAC update.
    always_comb begin
        w_src    = (r_state == MAC) ? w_acc[STEPS] : r_acc;
        w_beat   = (r_state == MAC) ? '0 : r_count + 1'b1;
        w_c_data = '0;
        for (int s = 0; s < STEPS; s++) begin
            if ((int'(w_beat) * STEPS + s) < N) begin
                w_c_data[2*s +: 2] = w_src[2*(int'(w_beat) * STEPS + s) +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start)                w_state_nxt = MAC;
            MAC:     if (w_a_fire && w_last_beat)  w_state_nxt = DRAIN;
            DRAIN:   if (w_c_fire && w_last_beat)  w_state_nxt = IDLE;
            default:                               w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_brot   <= '0;
            r_count  <= '0;
            r_c_data <= '0;
            r_c_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_acc   <= '0;
                    r_brot  <= w_b_norm;
                    r_count <= '0;
                end
                MAC: if (w_a_fire) begin
                    r_acc  <= w_acc[STEPS];
                    r_brot <= w_brot[STEPS];
                    if (w_last_beat) begin
                        r_count  <= '0;
                        r_c_data <= w_c_data;
                        r_c_last <= (BEATS == 1);
                    end else begin
                        r_count  <= r_count + 1'b1;
                    end
                end
                DRAIN: if (w_c_fire) begin
                    if (w_last_beat) begin
                        r_count  <= '0;
                        r_c_data <= '0;
                        r_c_last <= 1'b0;
                    end else begin
                        r_count  <= r_count + 1'b1;
                        r_c_data <= w_c_data;
                        r_c_last <= ((r_count + 1'b1) == LAST_BEAT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ter_cyclic_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_ter_cyclic_mul
// Brief    : Directed vector bench for ter_cyclic_mul with N=5, STEPS=2.
// Revision : 1.0
// ============================================================================
module tb_ter_cyclic_mul;

    localparam int N     = 5;
    localparam int STEPS = 2;
    localparam int BEATS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ter_cyclic_mul_if #(.N(N), .STEPS(STEPS)) bus ();

    ter_cyclic_mul #(.N(N), .STEPS(STEPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [9:0] b;
        logic [9:0] a;
        logic [1:0] pad;
        logic [9:0] c;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        case (v)
            1:       return 2'b01;
            -1:      return 2'b11;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [9:0] poly(input int c0, input int c1, input int c2,
                                        input int c3, input int c4);
        return {enc(c4), enc(c3), enc(c2), enc(c1), enc(c0)};
    endfunction

    task automatic run_product(input string tag, input logic [9:0] b, input logic [9:0] a,
                               input logic [1:0] pad, input int stall_beat,
                               output logic [9:0] c);
        logic [11:0] apad;
        logic [11:0] cbuf;
        logic [3:0]  held_data;
        logic        held_last;
        int          guard;
        int          beats;
        apad = {pad, a};
        cbuf = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy after start"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < BEATS; k++) begin
            bus.a_valid = 1'b1;
            bus.a_data  = apad[4*k +: 4];
            guard = 0;
            while (!bus.a_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) check({tag, " a_ready timeout"}, 32'd0, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        check({tag, " c_valid latency"}, 32'(bus.c_valid), 32'd1);
        check({tag, " a_ready low in drain"}, 32'(bus.a_ready), 32'd0);
        beats = 0;
        guard = 0;
        while (beats < BEATS && guard < 40) begin
            if (bus.c_valid) begin
                cbuf[4*beats +: 4] = bus.c_data;
                check({tag, " c_last"}, 32'(bus.c_last), 32'(beats == BEATS - 1));
                if (beats == stall_beat) begin
                    held_data   = bus.c_data;
                    held_last   = bus.c_last;
                    bus.c_ready = 1'b0;
                    for (int w = 0; w < 4; w++) begin
                        bus.start = 1'b1;
                        @(negedge clk);
                        check({tag, " stall c_valid"}, 32'(bus.c_valid), 32'd1);
                        check({tag, " stall c_data"}, 32'(bus.c_data), 32'(held_data));
                        check({tag, " stall c_last"}, 32'(bus.c_last), 32'(held_last));
                    end
                    bus.start = 1'b0;
                end
                bus.c_ready = 1'b1;
                beats++;
            end
            @(negedge clk);
            bus.c_ready = 1'b0;
            guard++;
        end
        check({tag, " result beats"}, 32'(beats), 32'(BEATS));
        check({tag, " idle after drain"}, 32'(bus.busy), 32'd0);
        check({tag, " padding output"}, 32'(cbuf[11:10]), 32'd0);
        c = cbuf[9:0];
    endtask

    logic [9:0] got;

    initial begin
        bus.start   = 1'b0;
        bus.b_in    = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.c_ready = 1'b0;

        vecs[0] = '{"identity",  poly(1,-1,0,1,0), poly(1,0,0,0,0),  2'b00, poly(1,-1,0,1,0)};
        vecs[1] = '{"wrap",      poly(1,-1,0,1,0), poly(0,0,0,0,1),  2'b00, poly(-1,0,1,0,1)};
        vecs[2] = '{"carry",     poly(1,1,0,0,0),  poly(1,1,0,0,0),  2'b00, poly(1,-1,1,0,0)};
        vecs[3] = '{"pad_norm",  poly(1,-1,2,1,0), poly(1,0,0,0,0),  2'b11, poly(1,-1,0,1,0)};
        vecs[4] = '{"pad_wrap",  poly(1,-1,2,1,0), poly(0,0,0,0,-1), 2'b11, poly(1,0,-1,0,-1)};

        repeat (3) @(negedge clk);
        check("reset a_ready", 32'(bus.a_ready), 32'd0);
        check("reset c_valid", 32'(bus.c_valid), 32'd0);
        check("reset c_last",  32'(bus.c_last),  32'd0);
        check("reset c_data",  32'(bus.c_data),  32'd0);
        check("reset busy",    32'(bus.busy),    32'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_product(vecs[v].name, vecs[v].b, vecs[v].a, vecs[v].pad, -1, got);
            check({vecs[v].name, " product"}, 32'(got), 32'(vecs[v].c));
        end

        // Dense product with a 4-cycle consumer stall and start pulses while busy.
        run_product("stall", poly(-1,0,1,1,0), poly(1,-1,1,0,1), 2'b00, 1, got);
        check("stall product", 32'(got), 32'(poly(0,-1,1,0,-1)));

        // Abandon an operation after one beat, then verify no stale accumulation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.b_in  = poly(1,1,1,1,1);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = {enc(1), enc(1)};
        @(negedge clk);
        bus.a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy",    32'(bus.busy),    32'd0);
        check("midrst a_ready", 32'(bus.a_ready), 32'd0);
        check("midrst c_valid", 32'(bus.c_valid), 32'd0);
        check("midrst c_data",  32'(bus.c_data),  32'd0);
        rst = 1'b0;
        run_product("after_rst", vecs[2].b, vecs[2].a, 2'b00, -1, got);
        check("after_rst product", 32'(got), 32'(vecs[2].c));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
